// File: rtl/fill_mem_responder.sv
// fill_mem_responder: pipelined main-memory responder for the cache fill
// state machine and the data-cache write-through path.
//
// Optional feature macro: FILL_MEM_ALIGN_CHECK_EN
//   defined   -> requests with addr[0]=1 are rejected and flagged on err
//   undefined -> addr[0] is ignored and err is tied low
//
// Request semantics: enable is a request-valid with an implicit, permanently
// asserted ready. Every rising edge with enable=1 (and rst released) accepts
// one request; there is no backpressure. Reads return exactly LATENCY edges
// after acceptance as a one-cycle data_valid pulse with no response handshake.
module fill_mem_responder #(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 16,
  parameter int LATENCY        = 4,
  parameter int MEM_WORDS_LOG2 = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic [3:0]        pending,
  output logic              err
);

  localparam int DEPTH = 1 << MEM_WORDS_LOG2;

  // Word array; deliberately not cleared by reset.
  logic [DATA_W-1:0] mem_q [DEPTH];

  // Read pipeline: stage 0 is loaded at the accepting edge, the last stage
  // drives the response outputs.
  logic [LATENCY-1:0] vld_q, vld_d;
  logic [DATA_W-1:0]  dat_q [LATENCY];
  logic [DATA_W-1:0]  dat_d [LATENCY];

  logic [3:0] pending_q, pending_d;
  logic       err_q, err_d;

  logic [MEM_WORDS_LOG2-1:0] word_idx;
  logic                      reject;
  logic                      rd_accept;
  logic                      wr_accept;
  logic                      unused_addr;

  // Address bits above MEM_WORDS_LOG2 are dropped, so addresses alias.
  assign word_idx    = addr[MEM_WORDS_LOG2:1];
  assign unused_addr = ^addr;

`ifdef FILL_MEM_ALIGN_CHECK_EN
  // Odd byte addresses are refused outright: no write, no pipeline entry.
  assign reject = enable & addr[0];
`else
  // addr[0] is ignored; the enclosing word is accessed.
  assign reject = 1'b0;
`endif

  assign rd_accept = enable & ~wr & ~reject;
  assign wr_accept = enable &  wr & ~reject;

  // Next-state for pipeline shift, outstanding-read count and error pulse.
  always_comb begin
    vld_d     = '0;
    for (int i = 0; i < LATENCY; i++) begin
      dat_d[i] = '0;
    end
    pending_d = pending_q;
    err_d     = 1'b0;

    // Array contents sampled now, so a later write cannot alter this read.
    vld_d[0] = rd_accept;
    dat_d[0] = rd_accept ? mem_q[word_idx] : '0;
    for (int i = 1; i < LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      dat_d[i] = dat_q[i-1];
    end

    // +1 on an accepted read, -1 when the last stage retires a valid entry.
    pending_d = pending_q + 4'(rd_accept) - 4'(vld_q[LATENCY-1]);
    err_d     = reject;
  end

  // State registers; the array write shares the reset guard so requests
  // presented during reset are ignored, while reset never touches contents.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q     <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        dat_q[i] <= '0;
      end
      pending_q <= '0;
      err_q     <= 1'b0;
    end else begin
      vld_q     <= vld_d;
      for (int i = 0; i < LATENCY; i++) begin
        dat_q[i] <= dat_d[i];
      end
      pending_q <= pending_d;
      err_q     <= err_d;
      if (wr_accept) begin
        mem_q[word_idx] <= data_in;
      end
    end
  end

  assign data_valid = vld_q[LATENCY-1];
  assign data_out   = vld_q[LATENCY-1] ? dat_q[LATENCY-1] : '0;
  assign pending    = pending_q;
  assign err        = err_q;

endmodule

// File: doc/fill_mem_responder.md
# fill_mem_responder

Pipelined main-memory responder that serves the cache fill state machine and the data-cache write-through path. It accepts one word request per cycle, applies writes at the accepting edge, and returns read data with a fixed `LATENCY`-cycle delay flagged by `data_valid`. It sits below both caches in the memory hierarchy and is the responding end of the fill protocol, whose initiator drives `addr` / `enable` / `wr`.

## Interface

**Parameters**
- `ADDR_W`, default 16: byte address width.
- `DATA_W`, default 16: word width.
- `LATENCY`, default 4: read latency in cycles, from the accepting edge to `data_valid`. Legal range 1..8.
- `MEM_WORDS_LOG2`, default 15: log2 of array depth in words. The array is indexed by `addr[MEM_WORDS_LOG2:1]`.

**Ports**
- `clk`, input, 1: clock; all state changes on the rising edge.
- `rst`, input, 1: asynchronous reset, active-low.
- `enable`, input, 1: request valid this cycle.
- `wr`, input, 1: request is a write when `enable`=1.
- `addr`, input, `ADDR_W`: byte address; word aligned.
- `data_in`, input, `DATA_W`: write data.
- `data_out`, output, `DATA_W`: read data; 0 whenever `data_valid`=0.
- `data_valid`, output, 1: `data_out` holds the response to the read accepted `LATENCY` edges earlier.
- `pending`, output, 4: number of reads accepted but not yet returned (0..`LATENCY`).
- `err`, output, 1: misaligned-request flag (see Configuration).

## Operation

- A request is accepted at every rising edge where `enable`=1. The block is never busy, so there is no backpressure.
- **Write** (`enable`=1, `wr`=1): `mem[addr[MEM_WORDS_LOG2:1]]` ← `data_in` at the accepting edge. No response is generated.
- **Read** (`enable`=1, `wr`=0): the array word is sampled at the accepting edge into pipeline stage 0, with its valid bit set. Stages shift by one each cycle. The last stage drives `data_out` / `data_valid`.
- **Ordering:** read data reflects array contents at acceptance.
  - A write accepted after a read does not alter that read's returned data.
  - A write accepted before a read is visible to it.
- **`pending`:**
  - +1 at an edge that accepts a read.
  - −1 at an edge where the last stage retires a valid entry.
  - Both events on the same edge leave it unchanged.
  - It never exceeds `LATENCY`.
- Idle cycles (`enable`=0) inject bubbles, i.e. valid=0 stages.
- The array is not cleared by reset. Contents are undefined until written; the bench preloads via hierarchical access.

## Timing

- **Reset** (`rst`=0, asynchronous): all stage valid bits cleared, `data_out`=0, `data_valid`=0, `pending`=0, `err`=0.
  - In-flight reads are discarded and never return.
  - Array contents are preserved.
  - Requests presented while `rst`=0 are ignored.
- **Read latency:** read accepted at edge N gives `data_valid`=1 in the cycle following edge N+`LATENCY`−1, i.e. after exactly `LATENCY` edges counting the accepting one.
  - With `LATENCY`=4, edge 0 accept means valid after edge 3.
- **Throughput:** back-to-back reads on consecutive cycles return on consecutive cycles, with `data_valid` held high continuously.
- `data_valid` is a single-cycle pulse per read, with no handshake or hold.
- **Address wrap:** `addr` bits above `MEM_WORDS_LOG2` are ignored, so addresses alias modulo the array size.

## Configuration

- **`FILL_MEM_ALIGN_CHECK_EN` defined:**
  - A request with `addr[0]`=1 is rejected. No write occurs, nothing enters the pipeline, and `pending` is unchanged.
  - `err` pulses high for one cycle following the rejecting edge.
- **Not defined:**
  - `addr[0]` is ignored, so the word at `addr & ~1` is accessed.
  - `err` is tied to 0.

## Test plan

1. **Preload and single read.** Preload `mem[0x10]`=0xBEEF, then read `addr`=0x0020 → `data_valid`=1 exactly 4 edges later with `data_out`=0xBEEF. `pending` goes 1,1,1,1,0.
2. **Back-to-back fill burst.** Eight consecutive reads of 0x0100..0x010E (preloaded 0x0001..0x0008) → eight consecutive valid cycles returning 0x0001..0x0008 in order. `pending` peaks at 4.
3. **Write-then-read and read-then-write ordering.**
   - Write 0x1234 to 0x0040, then read 0x0040 the next cycle → returns 0x1234.
   - Read 0x0042 (old 0x5555), then write 0x9999 to 0x0042 the next cycle → read returns 0x5555.
4. **Reset mid-flight.** Issue 3 reads, assert `rst`=0 after the 2nd edge → `data_valid` and `pending` drop to 0 immediately and no response appears after release. Previously written 0x1234 at 0x0040 is still readable.
5. **Alignment check.**
   - With `FILL_MEM_ALIGN_CHECK_EN`: write to 0x0041 → `err`=1 for one cycle, and `mem[0x20]` is unchanged.
   - Without the macro: the same write updates `mem[0x20]`, and `err` stays 0.
6. **Aliasing.** With `MEM_WORDS_LOG2`=15, write 0xAAAA to 0x0002, then read 0x0002 after idle gaps of 0, 1 and 3 cycles → each returns 0xAAAA with latency 4, and no spurious `data_valid` occurs during the gaps.
